datapath_ctrl: RTL
==================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces idle state and all outputs to reset values immediately.
REQ-003 start  in  1  request to execute instr; sampled only in state WAIT.
REQ-004 instr  in  16  instruction word; captured into internal IR on the edge that accepts start.
REQ-005 readnum, writenum  out  3 each  register file read and write addresses.
REQ-006 write  out  1  register file write enable.
REQ-007 loada, loadb, loadc, loads  out  1 each  load enables for pipeline registers A, B, C and status.
REQ-008 asel, bsel  out  1 each  ALU operand selects; asel=1 forces A operand to 0; bsel=1 selects immediate (unused, always 0).
REQ-009 vsel  out  1  writeback mux select; 1 = datapath_in, 0 = C register.
REQ-010 shift, ALUop  out  2 each  shifter code and ALU operation.
REQ-011 datapath_in  out  16  sign-extended IR[7:0] (sximm8), valid whenever IR holds a MOV-immediate.
REQ-012 busy  out  1  high in every state except WAIT.
REQ-013 done  out  1  one-cycle pulse in the final state of a legal instruction.
REQ-014 illegal  out  1  one-cycle pulse in DECODE when the opcode/op pair is unsupported.

Function
REQ-015 IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-016 States: WAIT, DECODE, WIMM, GETA, GETB, EXEC, WREG; state register updates on rising clk only.
REQ-017 WAIT: start=1 -> capture IR, go DECODE; start=0 -> stay; start in any other state is ignored.
REQ-018 DECODE: 110/10 -> WIMM; 110/00 or 101/11 -> GETB; 101/00, 101/01 or 101/10 -> GETA; any other pair -> illegal=1, return to WAIT.
REQ-019 WIMM: writenum=Rn, vsel=1, write=1, done=1; next WAIT.
REQ-020 GETA: readnum=Rn, loada=1; next GETB.
REQ-021 GETB: readnum=Rm, loadb=1; next EXEC.
REQ-022 EXEC: shift=sh, ALUop=op, bsel=0; asel=1 for opcode 110 and for 101/11, else asel=0; loadc=1 except CMP (101/01), where loads=1, loadc=0, done=1, next WAIT; otherwise next WREG.
REQ-023 MOV-register (110/00) drives ALUop=00 (add to zero) in EXEC, not op.
REQ-024 WREG: writenum=Rd, vsel=0, write=1, done=1; next WAIT.
REQ-025 Every control output not named for a state is 0 in that state; outputs are Moore (decoded from state and IR only).
REQ-026 Latency from accepting edge to done cycle: MOV-imm 2 cycles; MOV-reg/MVN 4; ADD/AND 5; CMP 4; illegal pulse 1 cycle after accept.
REQ-027 Back-to-back: start held high in the WAIT cycle following done is accepted, with no extra idle cycle.

Reset
REQ-028 reset=1 -> state WAIT, IR=0x0000, all outputs 0 (datapath_in=0x0000), asynchronously, including mid-instruction.
REQ-029 First accepted start after reset deassertion behaves identically to any later start; no partial writeback of an interrupted instruction occurs.

Verification
REQ-030 instr=0xD007 (MOV R0,#7), start 1 cycle -> cycle 2: writenum=0, vsel=1, write=1, datapath_in=0x0007, done=1; then WAIT.
REQ-031 instr=0xD1FE (MOV R1,#-2) -> WIMM with writenum=1, datapath_in=0xFFFE.
REQ-032 instr=0xA148 (ADD R2,R1,R0 LSL#1) -> GETA readnum=1 loada; GETB readnum=0 loadb; EXEC shift=01 ALUop=00 asel=0 loadc; WREG writenum=2 write vsel=0 done at cycle 5.
REQ-033 instr=0xA900 (CMP R1,R0) -> EXEC with loads=1, loadc=0, done=1 at cycle 4; write never asserted.
REQ-034 instr=0xE000 -> illegal=1 in cycle 1, no load/write strobe, back in WAIT at cycle 2; start during busy ignored.
REQ-035 reset asserted during EXEC of 0xA148 -> all strobes 0 same cycle, busy=0, no WREG write after release.

Source files
------------

// File: rtl/datapath_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : datapath_ctrl                                              |
// | Description : Multi-cycle controller sequencing register file, ALU and   |
// |               pipeline registers for MOV/MVN/ADD/AND/CMP instructions.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module datapath_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WIMM   = 3'd2;
    localparam logic [2:0] S_GETA   = 3'd3;
    localparam logic [2:0] S_GETB   = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_WREG   = 3'd6;

    localparam logic [2:0] C_OPC_MOV = 3'b110;
    localparam logic [2:0] C_OPC_ALU = 3'b101;

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_is_movi;
    logic       w_is_movr;
    logic       w_is_mvn;
    logic       w_is_cmp;
    logic       w_needs_a;

    assign w_opcode = ir_q[15:13];
    assign w_op     = ir_q[12:11];
    assign w_rn     = ir_q[10:8];
    assign w_rd     = ir_q[7:5];
    assign w_sh     = ir_q[4:3];
    assign w_rm     = ir_q[2:0];

    assign w_is_movi = (w_opcode == C_OPC_MOV) && (w_op == 2'b10);
    assign w_is_movr = (w_opcode == C_OPC_MOV) && (w_op == 2'b00);
    assign w_is_mvn  = (w_opcode == C_OPC_ALU) && (w_op == 2'b11);
    assign w_is_cmp  = (w_opcode == C_OPC_ALU) && (w_op == 2'b01);
    // ADD, CMP and AND are the only forms that read a first operand from Rn
    assign w_needs_a = (w_opcode == C_OPC_ALU) && (w_op != 2'b11);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_movi)
                    state_d = S_WIMM;
                else if (w_is_movr || w_is_mvn)
                    state_d = S_GETB;
                else if (w_needs_a)
                    state_d = S_GETA;
                else
                    state_d = S_WAIT;
            end
            S_WIMM:  state_d = S_WAIT;
            S_GETA:  state_d = S_GETB;
            S_GETB:  state_d = S_EXEC;
            S_EXEC:  state_d = w_is_cmp ? S_WAIT : S_WREG;
            S_WREG:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Reads zero while IR is cleared, so reset forces it low as well
    assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        busy     = (state_q != S_WAIT);
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_DECODE: begin
                illegal = !(w_is_movi || w_is_movr || w_is_mvn || w_needs_a);
            end
            S_WIMM: begin
                writenum = w_rn;
                vsel     = 1'b1;
                write    = 1'b1;
                done     = 1'b1;
            end
            S_GETA: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = w_rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = w_sh;
                ALUop = w_is_movr ? 2'b00 : w_op;
                asel  = (w_opcode == C_OPC_MOV) || w_is_mvn;
                if (w_is_cmp) begin
                    loads = 1'b1;
                    done  = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            S_WREG: begin
                writenum = w_rd;
                write    = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
